// File: rtl/operand_bus_arbiter.sv
// rtl/operand_bus_arbiter.sv - round-robin 7-source bus arbiter with burst hold and stall watchdog
// Optional macro ARB_FAST_REARB_EN: re-arbitrate in the cycle a burst ends, removing the dead cycle.
module operand_bus_arbiter #(
   parameter int N       = 32,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [6:0]   req,
   input  logic [6:0]   last,
   input  logic [N-1:0] d0,
   input  logic [N-1:0] d1,
   input  logic [N-1:0] d2,
   input  logic [N-1:0] d3,
   input  logic [N-1:0] d4,
   input  logic [N-1:0] d5,
   input  logic [N-1:0] d6,
   input  logic         bus_ready,
   output logic         bus_valid,
   output logic [N-1:0] bus_data,
   output logic [2:0]   sel,
   output logic [6:0]   grant,
   output logic         timeout_err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] wd;

   logic       win_found;
   logic [2:0] win;
   logic [3:0] cand;
   logic       owner_req;
   logic       beat;
   logic       end_last;
   logic       abort;
   logic       expire;

   // First requester at or after ptr, wrapping 6 -> 0.
   always_comb begin
      win_found = 1'b0;
      win       = ptr;
      cand      = 4'd0;
      for (int i = 0; i < 7; i++) begin
         cand = {1'b0, ptr} + 4'(i);
         if (cand >= 4'd7) cand = cand - 4'd7;
         if (!win_found && req[cand[2:0]]) begin
            win_found = 1'b1;
            win       = cand[2:0];
         end
      end
   end

   always_comb begin
      bus_data = d0;
      case (sel)
         3'd0:    bus_data = d0;
         3'd1:    bus_data = d1;
         3'd2:    bus_data = d2;
         3'd3:    bus_data = d3;
         3'd4:    bus_data = d4;
         3'd5:    bus_data = d5;
         3'd6:    bus_data = d6;
         default: bus_data = d0;
      endcase
   end

   // A completed beat counts as progress, so it always suppresses expiry.
   assign owner_req = req[sel];
   assign bus_valid = (state == BUSY) && owner_req;
   assign beat      = bus_valid && bus_ready;
   assign end_last  = beat && last[sel];
   assign abort     = (state == BUSY) && !owner_req;
   assign expire    = bus_valid && !beat && (wd == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         sel         <= '0;
         ptr         <= '0;
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  state <= BUSY;
                  grant <= 7'b1 << win;
                  sel   <= win;
                  ptr   <= (win == 3'd6) ? 3'd0 : win + 3'd1;
                  wd    <= '0;
               end
            end
            BUSY: begin
               if (end_last || abort) begin
`ifdef ARB_FAST_REARB_EN
                  // ptr already sits just past the outgoing owner, making it lowest priority.
                  if (win_found) begin
                     grant <= 7'b1 << win;
                     sel   <= win;
                     ptr   <= (win == 3'd6) ? 3'd0 : win + 3'd1;
                     wd    <= '0;
                  end else begin
                     state <= IDLE;
                     grant <= '0;
                  end
`else
                  state <= IDLE;
                  grant <= '0;
`endif
               end else if (expire) begin
                  state       <= IDLE;
                  grant       <= '0;
                  timeout_err <= 1'b1;
               end else if (beat) begin
                  wd <= '0;
               end else begin
                  wd <= wd + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// tb/tb_operand_bus_arbiter.sv - scenario and randomized checks for operand_bus_arbiter
module tb_operand_bus_arbiter;
   localparam int N = 16;
   localparam int TIMEOUT = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [6:0]   req;
   logic [6:0]   last;
   logic [N-1:0] dv [7];
   logic         bus_ready;
   logic         bus_valid;
   logic [N-1:0] bus_data;
   logic [2:0]   sel;
   logic [6:0]   grant;
   logic         timeout_err;

   int checks = 0;
   int passed = 0;

   // Reference model: owner index (-1 = idle), pointer, stall count, sticky error.
   int m_owner, m_sel, m_ptr, m_wd;
   bit m_terr;

   operand_bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .last(last),
      .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]), .d4(dv[4]), .d5(dv[5]), .d6(dv[6]),
      .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
      .sel(sel), .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; req = '0; last = '0; bus_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   function automatic int arb(input logic [6:0] r, input int p);
      for (int i = 0; i < 7; i++)
         if (r[(p + i) % 7]) return (p + i) % 7;
      return -1;
   endfunction

   task automatic model_grant(input int k);
      m_owner = k; m_sel = k; m_ptr = (k + 1) % 7; m_wd = 0;
   endtask

   task automatic model_step;
      int  k;
      bit  v, b;
      if (m_owner < 0) begin
         k = arb(req, m_ptr);
         if (k >= 0) model_grant(k);
      end else begin
         v = req[m_owner];
         b = v && bus_ready;
         if (!v || (b && last[m_owner])) begin
            m_owner = -1;
`ifdef ARB_FAST_REARB_EN
            k = arb(req, m_ptr);
            if (k >= 0) model_grant(k);
`endif
         end else if (b) m_wd = 0;
         else if (m_wd == TIMEOUT - 1) begin
            m_owner = -1; m_terr = 1'b1;
         end else m_wd++;
      end
   endtask

   task automatic test_reset;
      do_reset();
      checks++; if (grant !== 7'd0) $display("FAIL reset_grant got %b want 0", grant); else passed++;
      checks++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel); else passed++;
      checks++; if (bus_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus_valid); else passed++;
      checks++; if (bus_data !== dv[0]) $display("FAIL reset_data got %h want %h", bus_data, dv[0]); else passed++;
      checks++; if (timeout_err !== 1'b0) $display("FAIL reset_err got %b want 0", timeout_err); else passed++;
   endtask

   task automatic test_single;
      do_reset();
      req = 7'b0000100;
      tick();
      checks++; if (grant !== 7'b0000100) $display("FAIL single_grant got %b want 0000100", grant); else passed++;
      checks++; if (sel !== 3'd2) $display("FAIL single_sel got %0d want 2", sel); else passed++;
      checks++; if (bus_valid !== 1'b1) $display("FAIL single_valid got %b want 1", bus_valid); else passed++;
      checks++; if (bus_data !== dv[2]) $display("FAIL single_data got %h want %h", bus_data, dv[2]); else passed++;
      req = 7'b1111111; last = 7'b1111111; bus_ready = 1'b1;
      tick();
`ifndef ARB_FAST_REARB_EN
      checks++; if (grant !== 7'd0) $display("FAIL single_dead got %b want 0", grant); else passed++;
      tick();
`endif
      checks++; if (grant !== 7'b0001000) $display("FAIL single_ptr3 got %b want 0001000", grant); else passed++;
   endtask

   task automatic test_round_robin;
      do_reset();
      req = 7'b1111111; last = 7'b1111111; bus_ready = 1'b1;
      tick();
      for (int g = 0; g < 8; g++) begin
         checks++;
         if (grant !== (7'b1 << (g % 7)) || sel !== 3'(g % 7))
            $display("FAIL rr_grant step %0d got %b/%0d want src %0d", g, grant, sel, g % 7);
         else passed++;
         tick();
`ifndef ARB_FAST_REARB_EN
         checks++; if (grant !== 7'd0) $display("FAIL rr_dead step %0d got %b want 0", g, grant); else passed++;
         tick();
`endif
      end
   endtask

   task automatic test_burst;
      logic [5:0] pat;
      int beats;
      pat = 6'b101101;
      beats = 0;
      do_reset();
      req = 7'b0100000;
      tick();
      for (int i = 0; i < 6; i++) begin
         bus_ready = pat[5 - i];
         last = (bus_ready && beats == 3) ? 7'b0100000 : 7'd0;
         #1;
         if (bus_valid && bus_ready) beats++;
         checks++; if (grant !== 7'b0100000) $display("FAIL burst_hold cyc %0d got %b want 0100000", i, grant); else passed++;
         tick();
      end
      checks++; if (beats != 4) $display("FAIL burst_beats got %0d want 4", beats); else passed++;
`ifdef ARB_FAST_REARB_EN
      checks++; if (grant !== 7'b0100000) $display("FAIL burst_release got %b want 0100000", grant); else passed++;
`else
      checks++; if (grant !== 7'd0) $display("FAIL burst_release got %b want 0", grant); else passed++;
`endif
      req = '0; last = '0;
      tick();
   endtask

   task automatic test_timeout;
      do_reset();
      req = 7'b0000010;
      tick();
      for (int i = 1; i < TIMEOUT; i++) begin
         tick();
         checks++;
         if (grant !== 7'b0000010 || timeout_err !== 1'b0)
            $display("FAIL wd_hold cyc %0d got %b err %b want 0000010 err 0", i, grant, timeout_err);
         else passed++;
      end
      tick();
      checks++; if (grant !== 7'd0) $display("FAIL wd_release got %b want 0", grant); else passed++;
      checks++; if (timeout_err !== 1'b1) $display("FAIL wd_err got %b want 1", timeout_err); else passed++;
      req = 7'b0001000; bus_ready = 1'b1;
      tick();
      checks++; if (grant !== 7'b0001000) $display("FAIL wd_regrant got %b want 0001000", grant); else passed++;
      checks++; if (timeout_err !== 1'b1) $display("FAIL wd_sticky got %b want 1", timeout_err); else passed++;
      do_reset();
      checks++; if (timeout_err !== 1'b0) $display("FAIL wd_clear got %b want 0", timeout_err); else passed++;
   endtask

   task automatic test_abort;
      do_reset();
      req = 7'b0001000; bus_ready = 1'b1; last = '0;
      tick();
      tick();
      checks++; if (grant !== 7'b0001000) $display("FAIL abort_busy got %b want 0001000", grant); else passed++;
      req = '0;
      tick();
      checks++; if (grant !== 7'd0) $display("FAIL abort_idle got %b want 0", grant); else passed++;
      checks++; if (timeout_err !== 1'b0) $display("FAIL abort_err got %b want 0", timeout_err); else passed++;
      req = 7'b0011000;
      tick();
      checks++; if (grant !== 7'b0010000) $display("FAIL abort_ptr4 got %b want 0010000", grant); else passed++;
   endtask

   task automatic test_rst_mid;
      do_reset();
      req = 7'b1000000; bus_ready = 1'b1; last = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      checks++; if (grant !== 7'd0) $display("FAIL rstmid_grant got %b want 0", grant); else passed++;
      checks++; if (sel !== 3'd0) $display("FAIL rstmid_sel got %0d want 0", sel); else passed++;
      checks++; if (bus_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus_valid); else passed++;
      rst = 1'b0; req = 7'b1111111;
      tick();
      checks++; if (grant !== 7'b0000001) $display("FAIL rstmid_ptr0 got %b want 0000001", grant); else passed++;
   endtask

   task automatic test_random;
      do_reset();
      m_owner = -1; m_sel = 0; m_ptr = 0; m_wd = 0; m_terr = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 7; i++) begin
            if ($urandom_range(7) == 0) req[i] = ~req[i];
            dv[i] = N'($urandom);
         end
         last = 7'($urandom) & 7'($urandom);
         bus_ready = (c % 100 < 30) ? ($urandom_range(7) == 0) : ($urandom_range(3) != 0);
         #1;
         checks++;
         if (bus_valid !== (m_owner >= 0 && req[m_owner]) || bus_data !== dv[m_sel])
            $display("FAIL rand_bus cyc %0d got v=%b d=%h want v=%b d=%h", c, bus_valid, bus_data,
                     (m_owner >= 0 && req[m_owner]), dv[m_sel]);
         else passed++;
         model_step();
         tick();
         checks++;
         if (grant !== ((m_owner >= 0) ? (7'b1 << m_owner) : 7'd0) || sel !== 3'(m_sel)
             || timeout_err !== m_terr)
            $display("FAIL rand_state cyc %0d got g=%b s=%0d e=%b want owner %0d s=%0d e=%b",
                     c, grant, sel, timeout_err, m_owner, m_sel, m_terr);
         else passed++;
      end
   endtask

   initial begin
      for (int i = 0; i < 7; i++) dv[i] = N'(16'h1000 + i * 16'h0111);
      rst = 1'b1; req = '0; last = '0; bus_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_burst();
      test_timeout();
      test_abort();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
